// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button UI blocks.
package btn_pkg;

    // Width and ceiling of the millisecond counter used by the gesture FSM
    localparam int MS_CNT_W   = 12;
    localparam int MS_CNT_MAX = 4095;

    // Gesture FSM states; the 3-bit codes 5..7 are unused and recover to IDLE
    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        PRESSED        = 3'd1,
        LONG_HELD      = 3'd2,
        WAIT_SECOND    = 3'd3,
        SECOND_PRESSED = 3'd4
    } btn_state_t;

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running prescaler producing a one-cycle ms_tick every TICK_DIV clocks.
module ms_tick_gen #(
    parameter int TICK_DIV = 50_000
) (
    input  logic clk,
    input  logic reset,
    output logic ms_tick
);

    localparam int               CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Count 0..TICK_DIV-1 and wrap; never stalls so every timed block shares one phase
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign ms_tick = (cnt == LAST);

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced button activity into short press, long press,
// double click and (with BTN_AUTOREPEAT_EN defined) auto-repeat pulses.
// Without BTN_AUTOREPEAT_EN, repeat_tick is tied low and REPEAT_MS is unused.
module button_event_decoder
    import btn_pkg::*;
#(
    parameter int TICK_DIV  = 50_000,
    parameter int LONG_MS   = 800,
    parameter int DCLICK_MS = 250,
    parameter int REPEAT_MS = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic db_level,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic repeat_tick,
    output logic busy
);

    // Reject thresholds the 12-bit counter cannot represent
    if (TICK_DIV < 2 ||
        LONG_MS < 1 || LONG_MS > MS_CNT_MAX ||
        DCLICK_MS < 1 || DCLICK_MS > MS_CNT_MAX ||
        REPEAT_MS < 1 || REPEAT_MS > MS_CNT_MAX) begin : g_bad_cfg
        $error("button_event_decoder: parameter out of legal range");
    end

    localparam logic [MS_CNT_W-1:0] LONG_C   = MS_CNT_W'(LONG_MS);
    localparam logic [MS_CNT_W-1:0] DCLICK_C = MS_CNT_W'(DCLICK_MS);
    localparam logic [MS_CNT_W-1:0] CNT_TOP  = MS_CNT_W'(MS_CNT_MAX);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [MS_CNT_W-1:0] REPEAT_C = MS_CNT_W'(REPEAT_MS);
`endif

    logic                ms_tick;
    logic                lvl_q;
    logic                rise;
    logic                fall;
    logic [MS_CNT_W-1:0] ms_cnt;
    btn_state_t          state;

    // Saturating increment so a long idle period cannot wrap into a false match
    function automatic logic [MS_CNT_W-1:0] sat_inc(input logic [MS_CNT_W-1:0] v);
        return (v == CNT_TOP) ? v : v + MS_CNT_W'(1);
    endfunction

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .ms_tick (ms_tick)
    );

    // Edges are judged against the previous level so a press held through reset is seen
    assign rise = db_level & ~lvl_q;
    assign fall = ~db_level & lvl_q;

    // Gesture FSM with millisecond counter and registered one-cycle event outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_q        <= 1'b0;
            state        <= IDLE;
            ms_cnt       <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
            busy         <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            repeat_tick  <= 1'b0;
`endif
        end else begin
            lvl_q        <= db_level;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
            busy         <= (state != IDLE);
`ifdef BTN_AUTOREPEAT_EN
            repeat_tick  <= 1'b0;
`endif
            // Default counting; any state change below overrides with a clear
            if (ms_tick) begin
                ms_cnt <= sat_inc(ms_cnt);
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        state  <= PRESSED;
                        ms_cnt <= '0;
                    end
                end
                PRESSED: begin
                    // A release coinciding with the long threshold stays a short gesture
                    if (fall) begin
                        state  <= WAIT_SECOND;
                        ms_cnt <= '0;
                    end else if (ms_cnt == LONG_C) begin
                        long_press <= 1'b1;
                        state      <= LONG_HELD;
                        ms_cnt     <= '0;
                    end
                end
                LONG_HELD: begin
                    if (fall) begin
                        state  <= IDLE;
                        ms_cnt <= '0;
`ifdef BTN_AUTOREPEAT_EN
                    end else if (ms_cnt == REPEAT_C) begin
                        repeat_tick <= 1'b1;
                        ms_cnt      <= '0;
`endif
                    end
                end
                WAIT_SECOND: begin
                    // A second press wins over the timeout landing in the same cycle
                    if (rise) begin
                        state  <= SECOND_PRESSED;
                        ms_cnt <= '0;
                    end else if (ms_cnt == DCLICK_C) begin
                        short_press <= 1'b1;
                        state       <= IDLE;
                        ms_cnt      <= '0;
                    end
                end
                SECOND_PRESSED: begin
                    if (fall) begin
                        double_click <= 1'b1;
                        state        <= IDLE;
                        ms_cnt       <= '0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    ms_cnt <= '0;
                end
            endcase
        end
    end

`ifndef BTN_AUTOREPEAT_EN
    assign repeat_tick = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with short simulation timings.
module tb_button_event_decoder;

    localparam int TICK_DIV  = 10;
    localparam int LONG_MS   = 8;
    localparam int DCLICK_MS = 5;
    localparam int REPEAT_MS = 3;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic db_level = 1'b0;
    logic short_press, long_press, double_click, repeat_tick, busy;

    int cyc = 0;
    int n_tests = 0;
    int n_fail  = 0;

    int n_short = 0, n_long = 0, n_dclick = 0, n_rep = 0, n_multi = 0;
    int t_short = 0, t_long = 0, t_dclick = 0, t_rep_first = 0, t_rep_last = 0;

    button_event_decoder #(
        .TICK_DIV  (TICK_DIV),
        .LONG_MS   (LONG_MS),
        .DCLICK_MS (DCLICK_MS),
        .REPEAT_MS (REPEAT_MS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .db_level     (db_level),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_click (double_click),
        .repeat_tick  (repeat_tick),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: counts high cycles and remembers when each output was last seen
    always @(negedge clk) begin
        if (short_press)  begin n_short  = n_short + 1;  t_short  = cyc; end
        if (long_press)   begin n_long   = n_long + 1;   t_long   = cyc; end
        if (double_click) begin n_dclick = n_dclick + 1; t_dclick = cyc; end
        if (repeat_tick) begin
            if (n_rep == 0) t_rep_first = cyc;
            t_rep_last = cyc;
            n_rep = n_rep + 1;
        end
        if (int'(short_press) + int'(long_press) + int'(double_click) + int'(repeat_tick) > 1)
            n_multi = n_multi + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        n_short = 0; n_long = 0; n_dclick = 0; n_rep = 0; n_multi = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a new level at a falling edge; t is the cycle in which it is presented
    task automatic set_level(input logic v, output int t);
        @(negedge clk);
        db_level = v;
        t = cyc;
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_short"},  int'(short_press),  0);
        check({tag, "_long"},   int'(long_press),   0);
        check({tag, "_dclick"}, int'(double_click), 0);
        check({tag, "_repeat"}, int'(repeat_tick),  0);
        check({tag, "_busy"},   int'(busy),         0);
    endtask

    int tp, tr, tr2, trel, d, exp_rep;

    initial begin
        // Reset state
        idle(3);
        check_all_low("in_reset");
        @(negedge clk);
        reset = 1'b0;
        idle(5);
        check_all_low("after_reset");

        // Short press: 30 cycles held, then a lone release
        clear_counts();
        set_level(1'b1, tp);
        idle(10);
        check("short_busy_held", int'(busy), 1);
        idle(19);
        set_level(1'b0, tr);
        idle(70);
        d = t_short - tr;
        check("short_count", n_short, 1);
        check("short_latency_ok", int'(d >= 41 && d <= 52), 1);
        check("short_no_long", n_long, 0);
        check("short_no_dclick", n_dclick, 0);
        check("short_busy_idle", int'(busy), 0);

        // Long press held for 200 cycles
        clear_counts();
        set_level(1'b1, tp);
        idle(199);
        set_level(1'b0, tr);
        idle(10);
        d = t_long - tp;
        check("long_count", n_long, 1);
        check("long_latency_ok", int'(d >= 71 && d <= 82), 1);
        check("long_no_short", n_short, 0);
        check("long_no_dclick", n_dclick, 0);
`ifdef BTN_AUTOREPEAT_EN
        exp_rep = (tr - t_long) / 30;
        check("repeat_count", n_rep, exp_rep);
        check("repeat_first_gap", t_rep_first - t_long, 30);
        check("repeat_period", t_rep_last - t_rep_first, 30 * (n_rep - 1));
`else
        check("repeat_absent", n_rep, 0);
`endif
        idle(70);
        check("long_release_no_short", n_short, 0);

        // Double click: 20 on, 20 off, 20 on, release
        clear_counts();
        set_level(1'b1, tp);
        idle(19);
        set_level(1'b0, tr);
        idle(19);
        set_level(1'b1, tp);
        idle(19);
        set_level(1'b0, tr2);
        idle(70);
        check("dclick_count", n_dclick, 1);
        check("dclick_latency", t_dclick - tr2, 1);
        check("dclick_no_short", n_short, 0);
        check("dclick_no_long", n_long, 0);

        // Gap too long: two separate short presses
        clear_counts();
        set_level(1'b1, tp);
        idle(19);
        set_level(1'b0, tr);
        idle(69);
        set_level(1'b1, tp);
        idle(19);
        set_level(1'b0, tr2);
        idle(70);
        check("gap_short_count", n_short, 2);
        check("gap_no_dclick", n_dclick, 0);

        // Reset mid-hold: abort, then the held level counts as a fresh press
        clear_counts();
        set_level(1'b1, tp);
        idle(39);
        check("midrst_busy_before", int'(busy), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_low("midrst_during");
        reset = 1'b0;
        trel = cyc;
        idle(100);
        d = t_long - trel;
        check("midrst_long_count", n_long, 1);
        check("midrst_long_latency_ok", int'(d >= 71 && d <= 82), 1);
        set_level(1'b0, tr);
        idle(70);
        check("midrst_no_short", n_short, 0);

        // Boundary: release lands in the cycle ms_cnt equals LONG_MS (prescaler phase fixed by reset)
        clear_counts();
        @(negedge clk);
        reset = 1'b1;
        db_level = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        db_level = 1'b1;
        repeat (80) @(negedge clk);
        db_level = 1'b0;
        idle(70);
        check("bound_fall_prio_no_long", n_long, 0);
        check("bound_fall_prio_short", n_short, 1);

        // One cycle later the long press must already have fired
        clear_counts();
        @(negedge clk);
        reset = 1'b1;
        db_level = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        db_level = 1'b1;
        repeat (81) @(negedge clk);
        db_level = 1'b0;
        idle(70);
        check("bound_late_long", n_long, 1);
        check("bound_late_no_short", n_short, 0);
        check("exclusive_events", n_multi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
